// File: rtl/rnd_port_rx.sv
// rnd_port_rx: receives strobed random bytes from asynchronous pins into a FWFT FIFO
// with a valid/ready output stream, link status and drop accounting.
module rnd_port_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 2,
  parameter int FIFO_AW     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rnd_pin,
  input  logic               strb_pin,
  input  logic               link_rstn_pin,
  output logic [7:0]         m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               link_up,
  output logic               overflow,
  input  logic               ovf_clr,
  output logic [31:0]        byte_cnt,
  output logic [15:0]        drop_cnt
);
  localparam int DEPTH = 1 << FIFO_AW;
  typedef enum logic [1:0] {LINK_DOWN, WAIT_EDGE, SETTLE, CAPTURE} state_t;
  state_t                 state;
  logic [SYNC_STAGES-1:0] strb_sync, lrst_sync;
  logic                   strb_prev, strb_rise;
  logic [7:0]             rnd_q;
  logic [3:0]             cnt;
  logic [7:0]             mem [DEPTH];
  logic [FIFO_AW-1:0]     wptr, rptr, rnext;
  logic                   push, pop, full, acc, drop;
  assign link_up   = lrst_sync[SYNC_STAGES-1];
  assign strb_rise = strb_sync[SYNC_STAGES-1] && !strb_prev;
  assign m_valid   = fifo_level != '0;
  assign full      = fifo_level == (FIFO_AW+1)'(DEPTH);
  assign push      = state == CAPTURE && link_up;
  assign pop       = m_valid && m_ready;
  assign acc       = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign rnext     = rptr + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      strb_sync <= '0;
      lrst_sync <= '0;
      strb_prev <= 1'b0;
      rnd_q     <= '0;
    end else begin
      strb_sync <= {strb_sync[SYNC_STAGES-2:0], strb_pin};
      lrst_sync <= {lrst_sync[SYNC_STAGES-2:0], link_rstn_pin};
      strb_prev <= strb_sync[SYNC_STAGES-1];
      rnd_q     <= rnd_pin;
    end
  // A link drop in any state abandons the pending capture on the next cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= LINK_DOWN;
      cnt   <= '0;
    end else if (!link_up) begin
      state <= LINK_DOWN;
    end else begin
      case (state)
        LINK_DOWN: state <= WAIT_EDGE;
        WAIT_EDGE: if (strb_rise) begin
          state <= SETTLE;
          cnt   <= 4'(SETTLE_CYC - 1);
        end
        SETTLE:    if (cnt == '0) state <= CAPTURE; else cnt <= cnt - 1'b1;
        default:   state <= WAIT_EDGE;
      endcase
    end
  always_ff @(posedge clk)
    if (acc) mem[wptr] <= rnd_q;
  // m_data is a registered copy of the head so it resets to zero and holds when empty.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      m_data     <= '0;
      byte_cnt   <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (acc) wptr <= wptr + 1'b1;
      if (pop) rptr <= rnext;
      fifo_level <= fifo_level + (FIFO_AW+1)'(acc) - (FIFO_AW+1)'(pop);
      if (acc && (fifo_level == '0 || (pop && fifo_level == 1)))
        m_data <= rnd_q;
      else if (pop && fifo_level > 1)
        m_data <= mem[rnext];
      byte_cnt <= byte_cnt + 32'(acc);
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= ovf_clr ? 16'd1 : drop_cnt + 16'(drop_cnt != 16'hFFFF);
      end else if (ovf_clr) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
endmodule
